// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and the memory.
interface fetch_stage_if #(parameter int DATA_W = 32);
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the PC register, issues one outstanding imem
// request at a time and delivers responses into the IF/ID register with a one-entry skid.
module fetch_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_next,
  output logic              pc_hold,
  fetch_stage_if.master     imem,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_target,
  input  logic              halt,
  input  logic              stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] if_pc
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP, SKID} state_t;

  state_t            state;
  logic [DATA_W-1:0] skid_instr;
  logic [DATA_W-1:0] skid_pc;
  logic              slot_free;
  logic              acked;
  logic              issue;

  always_comb begin
    slot_free = !if_valid || !stall;
    acked     = (state == WAIT) && imem.imem_ack;
    issue     = ((state == IDLE) || acked) && !halt && !redirect && slot_free;
    pc_hold   = 1'b1;
    pc_next   = pc;
    if (!reset) begin
      pc_next = '0;
    end else if (redirect) begin
      pc_hold = 1'b0;
      pc_next = redirect_target;
    end else if (issue) begin
      pc_hold = 1'b0;
      pc_next = pc + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
      if_valid       <= 1'b0;
      if_instr       <= '0;
      if_pc          <= '0;
      skid_instr     <= '0;
      skid_pc        <= '0;
    end else begin
      // Decode consumes the IF/ID entry; a new response below may refill it.
      if (if_valid && !stall) if_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (issue) begin
            imem.imem_req  <= 1'b1;
            imem.imem_addr <= pc;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_ack) begin
            if (redirect) begin
              imem.imem_req <= 1'b0;
              state         <= IDLE;
            end else if (slot_free) begin
              if_valid <= 1'b1;
              if_instr <= imem.imem_rdata;
              if_pc    <= imem.imem_addr;
              if (issue) begin
                imem.imem_addr <= pc;
              end else begin
                imem.imem_req <= 1'b0;
                state         <= IDLE;
              end
            end else begin
              skid_instr    <= imem.imem_rdata;
              skid_pc       <= imem.imem_addr;
              imem.imem_req <= 1'b0;
              state         <= SKID;
            end
          end else if (redirect) begin
            state <= DROP;
          end
        end
        DROP: begin
          // Request stays up until the stale response arrives, then it is thrown away.
          if (imem.imem_ack) begin
            imem.imem_req <= 1'b0;
            state         <= IDLE;
          end
        end
        SKID: begin
          if (redirect) begin
            state <= IDLE;
          end else if (!stall) begin
            if_valid <= 1'b1;
            if_instr <= skid_instr;
            if_pc    <= skid_pc;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (redirect) if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a
// queue-based transaction model of the fetch stage.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc_r;
  logic [31:0] pc_next;
  logic        pc_hold;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  int          n_tests;
  int          n_fail;

  fetch_stage_if #(.DATA_W(32)) bus ();

  fetch_stage #(.DATA_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc_r),
    .pc_next         (pc_next),
    .pc_hold         (pc_hold),
    .imem            (bus),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .stall           (stall),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dword(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // One clock edge; the bench plays the PC register using the values seen before the edge.
  task automatic cycle();
    logic        h;
    logic [31:0] n;
    h = pc_hold;
    n = pc_next;
    @(posedge clk);
    #1;
    if (reset && !h) pc_r = n;
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    reset = 1'b0;
    halt = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    pc_r = start_pc;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pc_r = 32'h1234; redirect = 1'b1; redirect_target = 32'h55;
    halt = 1'b0; stall = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%h exp=0", bus.imem_req); end
    n_tests++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr); end
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid got=%h exp=0", if_valid); end
    n_tests++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_if_instr got=%h exp=0", if_instr); end
    n_tests++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_if_pc got=%h exp=0", if_pc); end
    n_tests++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL reset_pc_hold got=%h exp=1", pc_hold); end
    n_tests++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL reset_pc_next got=%h exp=0", pc_next); end
    redirect = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset(32'h0);
    #1;
    n_tests++; if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL seq_first_issue_hold got=%h exp=0", pc_hold); end
    n_tests++; if (pc_next !== 32'h1) begin n_fail++; $display("FAIL seq_first_issue_next got=%h exp=1", pc_next); end
    cycle();
    for (int k = 0; k < 3; k++) begin
      bus.imem_ack = 1'b0;
      #1;
      n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req k=%0d got=%h exp=1", k, bus.imem_req); end
      n_tests++; if (bus.imem_addr !== 32'(k)) begin n_fail++; $display("FAIL seq_addr got=%h exp=%h", bus.imem_addr, 32'(k)); end
      n_tests++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL seq_wait_hold k=%0d got=%h exp=1", k, pc_hold); end
      if (k > 0) begin
        n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_if_valid k=%0d got=%h exp=1", k, if_valid); end
        n_tests++; if (if_instr !== dword(32'(k - 1))) begin n_fail++; $display("FAIL seq_if_instr got=%h exp=%h", if_instr, dword(32'(k - 1))); end
        n_tests++; if (if_pc !== 32'(k - 1)) begin n_fail++; $display("FAIL seq_if_pc got=%h exp=%h", if_pc, 32'(k - 1)); end
      end
      cycle();
      bus.imem_ack = 1'b1;
      bus.imem_rdata = dword(32'(k));
      #1;
      n_tests++; if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL seq_ack_hold k=%0d got=%h exp=0", k, pc_hold); end
      n_tests++; if (pc_next !== 32'(k + 2)) begin n_fail++; $display("FAIL seq_ack_next got=%h exp=%h", pc_next, 32'(k + 2)); end
      cycle();
    end
    bus.imem_ack = 1'b0;
    #1;
    n_tests++; if (if_instr !== dword(32'h2)) begin n_fail++; $display("FAIL seq_last_instr got=%h exp=%h", if_instr, dword(32'h2)); end
    n_tests++; if (if_pc !== 32'h2) begin n_fail++; $display("FAIL seq_last_pc got=%h exp=2", if_pc); end
  endtask

  task automatic test_skid();
    do_reset(32'h10);
    #1;
    cycle();
    bus.imem_ack = 1'b1; bus.imem_rdata = dword(32'h10);
    #1;
    cycle();
    stall = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = dword(32'h11);
    #1;
    n_tests++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL skid_capture_hold got=%h exp=1", pc_hold); end
    cycle();
    bus.imem_ack = 1'b0;
    #1;
    n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL skid_if_valid got=%h exp=1", if_valid); end
    n_tests++; if (if_pc !== 32'h10) begin n_fail++; $display("FAIL skid_held_pc got=%h exp=10", if_pc); end
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL skid_req got=%h exp=0", bus.imem_req); end
    n_tests++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL skid_hold got=%h exp=1", pc_hold); end
    cycle();
    n_tests++; if (if_pc !== 32'h10) begin n_fail++; $display("FAIL skid_held_pc2 got=%h exp=10", if_pc); end
    n_tests++; if (if_instr !== dword(32'h10)) begin n_fail++; $display("FAIL skid_held_instr got=%h exp=%h", if_instr, dword(32'h10)); end
    stall = 1'b0;
    #1;
    n_tests++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL skid_release_hold got=%h exp=1", pc_hold); end
    cycle();
    n_tests++; if (if_pc !== 32'h11) begin n_fail++; $display("FAIL skid_out_pc got=%h exp=11", if_pc); end
    n_tests++; if (if_instr !== dword(32'h11)) begin n_fail++; $display("FAIL skid_out_instr got=%h exp=%h", if_instr, dword(32'h11)); end
    n_tests++; if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL skid_resume_hold got=%h exp=0", pc_hold); end
    n_tests++; if (pc_next !== 32'h13) begin n_fail++; $display("FAIL skid_resume_next got=%h exp=13", pc_next); end
  endtask

  task automatic test_redirect_drop();
    do_reset(32'h20);
    #1;
    cycle();
    redirect = 1'b1; redirect_target = 32'h80;
    #1;
    n_tests++; if (pc_next !== 32'h80) begin n_fail++; $display("FAIL redir_next got=%h exp=80", pc_next); end
    n_tests++; if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL redir_hold got=%h exp=0", pc_hold); end
    cycle();
    redirect = 1'b0;
    #1;
    n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20) begin n_fail++; $display("FAIL redir_pending got=%h/%h exp=1/20", bus.imem_req, bus.imem_addr); end
    n_tests++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL redir_drop_hold got=%h exp=1", pc_hold); end
    cycle();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    #1;
    n_tests++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL redir_dropack_hold got=%h exp=1", pc_hold); end
    cycle();
    bus.imem_ack = 1'b0;
    #1;
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_dropped_valid got=%h exp=0", if_valid); end
    n_tests++; if (pc_hold !== 1'b0 || pc_next !== 32'h81) begin n_fail++; $display("FAIL redir_reissue got=%h/%h exp=0/81", pc_hold, pc_next); end
    cycle();
    n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin n_fail++; $display("FAIL redir_new_addr got=%h/%h exp=1/80", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_halt();
    do_reset(32'h5);
    #1;
    cycle();
    halt = 1'b1;
    #1;
    n_tests++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL halt_wait_hold got=%h exp=1", pc_hold); end
    cycle();
    bus.imem_ack = 1'b1; bus.imem_rdata = dword(32'h5);
    #1;
    n_tests++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL halt_ack_hold got=%h exp=1", pc_hold); end
    cycle();
    bus.imem_ack = 1'b0;
    #1;
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h5) begin n_fail++; $display("FAIL halt_capture got=%h/%h exp=1/5", if_valid, if_pc); end
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_no_req got=%h exp=0", bus.imem_req); end
    cycle();
    n_tests++; if (bus.imem_req !== 1'b0 || pc_hold !== 1'b1) begin n_fail++; $display("FAIL halt_idle got=%h/%h exp=0/1", bus.imem_req, pc_hold); end
    cycle();
    halt = 1'b0;
    #1;
    n_tests++; if (pc_hold !== 1'b0 || pc_next !== 32'h7) begin n_fail++; $display("FAIL halt_release got=%h/%h exp=0/7", pc_hold, pc_next); end
    cycle();
    n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h6) begin n_fail++; $display("FAIL halt_resume_addr got=%h/%h exp=1/6", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset(32'hFFFF_FFFF);
    #1;
    n_tests++; if (pc_hold !== 1'b0 || pc_next !== 32'h0) begin n_fail++; $display("FAIL wrap_next got=%h/%h exp=0/0", pc_hold, pc_next); end
    cycle();
    n_tests++; if (bus.imem_addr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_addr got=%h exp=ffffffff", bus.imem_addr); end
  endtask

  task automatic test_async_reset();
    do_reset(32'h40);
    #1;
    cycle();
    bus.imem_ack = 1'b1; bus.imem_rdata = dword(32'h40);
    #1;
    cycle();
    bus.imem_ack = 1'b0; stall = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL async_req got=%h exp=0", bus.imem_req); end
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL async_if_valid got=%h exp=0", if_valid); end
    n_tests++; if (pc_hold !== 1'b1 || pc_next !== 32'h0) begin n_fail++; $display("FAIL async_pc got=%h/%h exp=1/0", pc_hold, pc_next); end
    @(posedge clk);
    #1;
    reset = 1'b1; halt = 1'b1; stall = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_0000;
    #1;
    cycle();
    n_tests++; if (if_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stale_ack got=%h/%h exp=0/0", if_valid, bus.imem_req); end
    bus.imem_ack = 1'b0; halt = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  task automatic test_random();
    ent_t        bq[$];
    bit          m_out;
    bit          m_drop;
    logic [31:0] m_addr;
    bit          can_take;
    bit          free;
    bit          e_issue;
    bit          e_hold;
    logic [31:0] e_next;
    logic [31:0] new_pc;
    do_reset($urandom);
    m_out = 1'b0; m_drop = 1'b0; m_addr = '0;
    for (int i = 0; i < 1500; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      halt = ($urandom_range(0, 9) == 0);
      redirect = ($urandom_range(0, 12) == 0);
      redirect_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.imem_ack = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      bus.imem_rdata = (m_out && bus.imem_ack) ? dword(m_addr) : $urandom;
      #1;
      can_take = !m_out || (bus.imem_ack && !m_drop);
      free = (bq.size() == 0) || !stall;
      e_issue = can_take && !halt && !redirect && free && (bq.size() < 2);
      e_hold = !(redirect || e_issue);
      e_next = redirect ? redirect_target : pc_r + 32'h1;
      n_tests++; if (pc_hold !== e_hold) begin n_fail++; $display("FAIL rnd_hold cyc=%0d got=%h exp=%h", i, pc_hold, e_hold); end
      if (!e_hold) begin
        n_tests++; if (pc_next !== e_next) begin n_fail++; $display("FAIL rnd_next cyc=%0d got=%h exp=%h", i, pc_next, e_next); end
      end
      n_tests++; if (bus.imem_req !== m_out) begin n_fail++; $display("FAIL rnd_req cyc=%0d got=%h exp=%h", i, bus.imem_req, m_out); end
      if (m_out) begin
        n_tests++; if (bus.imem_addr !== m_addr) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, bus.imem_addr, m_addr); end
      end
      n_tests++; if (if_valid !== (bq.size() > 0)) begin n_fail++; $display("FAIL rnd_if_valid cyc=%0d got=%h exp=%h", i, if_valid, bq.size() > 0); end
      if (bq.size() > 0) begin
        n_tests++; if (if_instr !== bq[0].instr || if_pc !== bq[0].pc) begin n_fail++; $display("FAIL rnd_ifid cyc=%0d got=%h@%h exp=%h@%h", i, if_instr, if_pc, bq[0].instr, bq[0].pc); end
      end
      if (redirect) begin
        bq.delete();
        if (m_out) begin
          if (bus.imem_ack) begin m_out = 1'b0; m_drop = 1'b0; end
          else m_drop = 1'b1;
        end
      end else begin
        if (bq.size() > 0 && !stall) void'(bq.pop_front());
        if (m_out && bus.imem_ack) begin
          if (!m_drop) bq.push_back('{dword(m_addr), m_addr});
          m_out = 1'b0;
          m_drop = 1'b0;
        end
      end
      if (e_issue) begin m_out = 1'b1; m_addr = pc_r; m_drop = 1'b0; end
      new_pc = e_hold ? pc_r : e_next;
      @(posedge clk);
      #1;
      pc_r = new_pc;
    end
    redirect = 1'b0; halt = 1'b0; stall = 1'b0; bus.imem_ack = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    reset = 1'b0;
    pc_r = '0;
    halt = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    #2;
    test_reset();
    test_sequential();
    test_skid();
    test_redirect_drop();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low; reset=0 forces reset state immediately, independent of clk.
REQ-003 SHALL have port pc  in  32  current PC value from the PC register.
REQ-004 SHALL have port pc_next  out  32  next-PC value to the PC register data input.
REQ-005 SHALL have port pc_hold  out  1  1 = PC register keeps its value; 0 = PC loads pc_next.
REQ-006 SHALL have ports imem_req out 1, imem_addr out 32, imem_ack in 1, imem_rdata in 32  instruction memory request/response.
REQ-007 SHALL have ports redirect in 1, redirect_target in 32  taken branch or jump from a later stage.
REQ-008 SHALL have ports halt in 1, stall in 1  stop fetching; downstream cannot accept.
REQ-009 SHALL have ports if_valid out 1, if_instr out 32, if_pc out 32  IF/ID register toward decode.

Function
REQ-010 SHALL use word addressing: sequential pc_next = pc + 1, modulo 2^32 (0xFFFFFFFF wraps to 0).
REQ-011 SHALL implement FSM states IDLE, WAIT, DROP, SKID.
REQ-012 Issue condition: state IDLE, or WAIT with imem_ack=1, AND halt=0, redirect=0, slot free (if_valid=0 or stall=0), state not SKID.
REQ-013 On issue SHALL register imem_addr=pc, drive imem_req=1 from the next cycle, output pc_hold=0 with pc_next=pc+1 in the issue cycle, and enter WAIT.
REQ-014 imem_req SHALL stay 1 with imem_addr stable in WAIT/DROP until imem_ack=1; requests are never withdrawn.
REQ-015 WAIT with imem_ack=1 and slot free: next cycle if_valid=1, if_instr=imem_rdata, if_pc=registered imem_addr.
REQ-016 WAIT with imem_ack=1, if_valid=1, stall=1: response SHALL be captured in a one-entry skid buffer; go to SKID; no issue.
REQ-017 SKID: when stall=0, skid contents SHALL load into IF/ID next cycle; go to IDLE.
REQ-018 if_instr and if_pc SHALL hold while if_valid=1 and stall=1; if_valid clears after consumption when no new response arrives.
REQ-019 Redirect (priority over halt, stall, sequential): pc_next=redirect_target, pc_hold=0 that cycle; if_valid and skid cleared next cycle.
REQ-020 Redirect in WAIT without ack SHALL go to DROP; the pending response is discarded on ack, then IDLE.
REQ-021 Redirect in WAIT with ack in the same cycle SHALL discard that response and go to IDLE.
REQ-022 halt=1 SHALL block new issues and force pc_hold=1 (absent redirect); an outstanding request completes normally; FSM settles in IDLE.
REQ-023 pc_hold SHALL be 1 in every cycle not covered by REQ-013 or REQ-019.
REQ-024 halt release SHALL resume fetch from the current pc value with no lost or duplicated instruction.

Reset
REQ-025 While reset=0: state=IDLE, imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_pc=0, skid empty, pc_hold=1, pc_next=0.
REQ-026 Reset assertion mid-request SHALL abandon it; any ack arriving after reset release in IDLE is ignored.
REQ-027 First issue SHALL occur in the first clk edge cycle after reset=1 with halt=0.

Verification
REQ-028 Reset release, pc=0, ack one cycle after each req -> imem_addr 0,1,2; if_instr follows rdata; pc_hold=0 only on issue cycles.
REQ-029 pc=0x10, stall=1 while if_valid=1, ack arrives -> SKID entered, if_pc=0x10 held; stall=0 -> skid word (pc 0x11) appears next cycle.
REQ-030 WAIT at addr 0x20 with no ack, redirect=1 target 0x80 -> pc_next=0x80, pc_hold=0; ack for 0x20 dropped; next imem_addr=0x80.
REQ-031 halt=1 during WAIT at 0x5 -> ack captured at if_pc=0x5, no further req, pc_hold=1; halt=0 -> next imem_addr=0x6.
REQ-032 pc=0xFFFFFFFF issued -> pc_next=0x00000000.
REQ-033 reset=0 asynchronously mid-WAIT -> imem_req=0, if_valid=0 immediately without clk edge.
